// File: rtl/zap_ram_arb_pkg.sv
// zap_ram_arb_pkg: shared width helper and read-tag type for the RAM read arbiter
package zap_ram_arb_pkg;
    localparam int MAX_NREQ = 4;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int MAX_IW = idx_w(MAX_NREQ);
    typedef struct packed {
        logic              v;
        logic [MAX_IW-1:0] id;
    } tag_t;
endpackage

// File: rtl/zap_ram_arb_tagpipe.sv
// zap_ram_arb_tagpipe: RD_LAT-deep clock-enabled tag shift register (i_tag in at stage 0, o_tag from last stage)
module zap_ram_arb_tagpipe
    import zap_ram_arb_pkg::*;
#(
    parameter int RD_LAT = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clken,
    input  tag_t i_tag,
    output tag_t o_tag
);
    tag_t tag_q [RD_LAT];
    tag_t tag_d [RD_LAT];

    always_comb begin
        tag_d[0] = i_clken ? i_tag : tag_q[0];
        for (int i = 1; i < RD_LAT; i++)
            tag_d[i] = i_clken ? tag_q[i-1] : tag_q[i];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            for (int i = 0; i < RD_LAT; i++)
                tag_q[i] <= '0;
        else
            for (int i = 0; i < RD_LAT; i++)
                tag_q[i] <= tag_d[i];
    end

    assign o_tag = tag_q[RD_LAT-1];
endmodule

// File: rtl/zap_ram_rd_arbiter.sv
// zap_ram_rd_arbiter: round-robin read-port arbiter with latency-matched response steering; requester ports i_rd_*/o_rd_*, write pass-through i_wr_*, macro side o_ram_*/i_ram_rd_data
module zap_ram_rd_arbiter
    import zap_ram_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NREQ   = 2,
    parameter int RD_LAT = 3,
    localparam int AW = idx_w(DEPTH),
    localparam int IW = idx_w(NREQ),
    localparam int CW = idx_w(RD_LAT + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clken,
    input  logic [NREQ-1:0]    i_rd_req,
    input  logic [NREQ*AW-1:0] i_rd_addr,
    output logic [NREQ-1:0]    o_rd_gnt,
    output logic [NREQ-1:0]    o_rd_valid,
    output logic [WIDTH-1:0]   o_rd_data,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    output logic               o_ram_clken,
    output logic               o_ram_wr_en,
    output logic [AW-1:0]      o_ram_wr_addr,
    output logic [WIDTH-1:0]   o_ram_wr_data,
    output logic [AW-1:0]      o_ram_rd_addr,
    input  logic [WIDTH-1:0]   i_ram_rd_data,
    output logic [CW-1:0]      o_inflight
);
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, win, idx;
    logic [AW-1:0] last_addr_q, last_addr_d, win_addr;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          found, xfer, retire;
    tag_t          head, tail;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && i_rd_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        xfer        = found & i_clken;
        win_addr    = i_rd_addr[int'(win)*AW +: AW];
        retire      = tail.v & i_clken;
        head        = '{v: xfer, id: MAX_IW'(win)};
        rr_ptr_d    = xfer ? IW'((int'(win) + 1) % NREQ) : rr_ptr_q;
        last_addr_d = xfer ? win_addr : last_addr_q;
        inflight_d  = inflight_q + CW'(xfer) - CW'(retire);
        o_rd_valid  = '0;
        for (int k = 0; k < NREQ; k++)
            o_rd_valid[k] = retire & (tail.id == MAX_IW'(k));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr_q    <= '0;
            last_addr_q <= '0;
            inflight_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
        end
    end

    zap_ram_arb_tagpipe #(.RD_LAT(RD_LAT)) u_tagpipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clken (i_clken),
        .i_tag   (head),
        .o_tag   (tail)
    );

    assign o_rd_gnt      = xfer ? NREQ'(1) << win : '0;
    assign o_rd_data     = i_ram_rd_data;
    assign o_ram_clken   = i_clken;
    assign o_ram_wr_en   = i_wr_en & i_clken;
    assign o_ram_wr_addr = i_wr_addr;
    assign o_ram_wr_data = i_wr_data;
    assign o_ram_rd_addr = xfer ? win_addr : last_addr_q;
    assign o_inflight    = inflight_q;
endmodule
